// File: rtl/aud_recorder_mc.sv
// aud_recorder_mc: I2S ADC capture engine for the WM8731 path. Deserialises
// one or two channels of DATA_W-bit samples and hands each word to the SRAM
// write port over valid/ready. Stereo words are interleaved. Control is
// frame-aligned, and the block adds a length limit and overflow detection.
module aud_recorder_mc #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 20,
  parameter int N_CH    = 2,
  parameter int MAX_LEN = 2**20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W:0]   o_recd_len,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overflow
);

  localparam int              CNT_W   = $clog2(DATA_W);
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SHIFT,
    S_WAIT_CH,
    S_PAUSE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_lrc_d;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_ch;
  logic [DATA_W-1:0]  r_shift;
  logic               r_word_rdy;
  logic [ADDR_W:0]    r_word_cnt;
  logic               r_pause_def;
  logic               r_stop_def;

  logic               w_req_stop;
  logic               w_req_pause;
  logic               w_req_start;
  logic               w_lrc_rise;
  logic               w_lrc_fall;
  logic               w_last_bit;
  logic               w_last_ch;
  logic               w_frame_end;
  logic               w_limit;
  logic               w_shift_en;
  logic               w_enter_ch0;
  logic               w_enter_ch1;
  logic               w_defer;
  logic               w_clr_run;
  logic [ADDR_W:0]    w_addr_p1;

  // Stop outranks pause, and pause outranks start, on any given cycle.
  assign w_req_stop  = i_stop;
  assign w_req_pause = i_pause & ~i_stop;
  assign w_req_start = i_start & ~i_pause & ~i_stop;

  assign w_lrc_rise  = i_lrc & ~r_lrc_d;
  assign w_lrc_fall  = ~i_lrc & r_lrc_d;
  assign w_last_bit  = (r_state == S_SHIFT) && (r_bit_cnt == CNT_W'(DATA_W-1));
  assign w_last_ch   = (r_ch == 1'(N_CH-1));
  assign w_frame_end = w_last_bit & w_last_ch;
  // The word finishing at frame end has not been counted yet, so look one ahead.
  assign w_limit     = ((r_word_cnt + ONE_CNT) == MAX_CNT);
  assign w_addr_p1   = {1'b0, o_address} + ONE_CNT;

  // State register; o_busy is a registered copy of "not idle".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      o_busy  <= 1'b0;
    end else begin
      // NOTE: clocked state always uses non-blocking assignments, so every
      // process reads the pre-edge values regardless of evaluation order.
      r_state <= w_state_nxt;
      o_busy  <= (r_state != S_IDLE);
    end
  end

  // Next-state logic: immediate requests in ARMED/PAUSE, deferred ones at frame end.
  always_comb begin
    // NOTE: default first, so no path leaves the signal unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_start) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_req_stop)       w_state_nxt = S_IDLE;
        else if (w_req_pause) w_state_nxt = S_PAUSE;
        else if (w_lrc_rise)  w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last_bit) begin
          if (!w_last_ch)                       w_state_nxt = S_WAIT_CH;
          else if (w_limit || r_stop_def || i_stop) w_state_nxt = S_IDLE;
          else if (r_pause_def || i_pause)      w_state_nxt = S_PAUSE;
          else                                  w_state_nxt = S_ARMED;
        end
      end
      S_WAIT_CH: begin
        if (w_lrc_fall) w_state_nxt = S_SHIFT;
      end
      S_PAUSE: begin
        if (w_req_stop)       w_state_nxt = S_IDLE;
        else if (w_req_start) w_state_nxt = S_ARMED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: per-state strobes that steer the datapath.
  always_comb begin
    w_shift_en  = (r_state == S_SHIFT);
    w_enter_ch0 = (r_state == S_ARMED) && (w_state_nxt == S_SHIFT);
    w_enter_ch1 = (r_state == S_WAIT_CH) && w_lrc_fall;
    w_defer     = (r_state == S_SHIFT) || (r_state == S_WAIT_CH);
    w_clr_run   = (r_state == S_IDLE) && w_req_start;
  end

  // Serial capture: LRC history, bit/channel counters, shift register, requests held for frame end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc_d     <= 1'b0;
      r_bit_cnt   <= '0;
      r_ch        <= 1'b0;
      r_shift     <= '0;
      r_word_rdy  <= 1'b0;
      r_pause_def <= 1'b0;
      r_stop_def  <= 1'b0;
    end else begin
      r_lrc_d     <= i_lrc;
      r_word_rdy  <= w_last_bit;
      r_stop_def  <= w_defer && !w_frame_end && (r_stop_def  || i_stop);
      r_pause_def <= w_defer && !w_frame_end && (r_pause_def || i_pause);
      if (w_shift_en) begin
        r_shift   <= {r_shift[DATA_W-2:0], i_data};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_enter_ch0) begin
        r_ch      <= 1'b0;
        r_bit_cnt <= '0;
      end
      if (w_enter_ch1) begin
        r_ch      <= 1'b1;
        r_bit_cnt <= '0;
      end
    end
  end

  // Write port: hand off completed words, track accepted length, flag drops and the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_address  <= '0;
      o_data     <= '0;
      o_wr_valid <= 1'b0;
      o_recd_len <= '0;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (o_wr_valid && i_wr_ready) begin
        o_wr_valid <= 1'b0;
        if (w_addr_p1 > o_recd_len) o_recd_len <= w_addr_p1;
      end
      // NOTE: a later non-blocking assignment in the same block wins, so a
      // word loading on the accepting edge keeps o_wr_valid high.
      if (r_word_rdy) begin
        if (!o_wr_valid || i_wr_ready) begin
          o_data     <= r_shift;
          o_address  <= r_word_cnt[ADDR_W-1:0];
          o_wr_valid <= 1'b1;
        end else begin
          o_overflow <= 1'b1;
        end
        r_word_cnt <= r_word_cnt + ONE_CNT;
        if (w_limit) o_full <= 1'b1;
      end
      if (w_clr_run) begin
        r_word_cnt <= '0;
        o_recd_len <= '0;
        o_full     <= 1'b0;
        o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder_mc.sv
// tb_aud_recorder_mc: directed bench for aud_recorder_mc.
// A mono 16-bit instance and a stereo 24-bit instance with MAX_LEN=8 share
// one I2S stream of 64 BCLK per frame and 32-bit slots.
module tb_aud_recorder_mc;

  localparam int DW_M = 16;
  localparam int AW_M = 4;
  localparam int DW_S = 24;
  localparam int AW_S = 4;

  localparam logic [31:0] SL_SLOT = 32'h1234_569A;
  localparam logic [31:0] SR_SLOT = 32'hABCD_EF55;
  localparam logic [23:0] SL      = 24'h123456;
  localparam logic [23:0] SR      = 24'hABCDEF;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_lrc   = 1'b0;
  logic i_data  = 1'b0;
  logic start_m = 1'b0;
  logic pause_m = 1'b0;
  logic stop_m  = 1'b0;
  logic start_s = 1'b0;
  logic pause_s = 1'b0;
  logic stop_s  = 1'b0;
  logic ready_s = 1'b1;

  logic [AW_M-1:0] addr_m;
  logic [DW_M-1:0] data_m;
  logic            valid_m;
  logic [AW_M:0]   len_m;
  logic            busy_m, full_m, ovf_m;

  logic [AW_S-1:0] addr_s;
  logic [DW_S-1:0] data_s;
  logic            valid_s;
  logic [AW_S:0]   len_s;
  logic            busy_s, full_s, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lrc_rise_cyc = 0;
  int s_rise_delta = -1;
  bit s_rise_seen  = 1'b1;
  logic s_valid_q  = 1'b0;

  logic [AW_M-1:0] m_addr_q [$];
  logic [DW_M-1:0] m_data_q [$];
  logic [AW_S-1:0] s_addr_q [$];
  logic [DW_S-1:0] s_data_q [$];
  logic            s_busy_q [$];

  aud_recorder_mc #(.DATA_W(DW_M), .ADDR_W(AW_M), .N_CH(1), .MAX_LEN(16)) u_mono (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_data(i_data),
    .i_start(start_m), .i_pause(pause_m), .i_stop(stop_m),
    .o_address(addr_m), .o_data(data_m), .o_wr_valid(valid_m), .i_wr_ready(1'b1),
    .o_recd_len(len_m), .o_busy(busy_m), .o_full(full_m), .o_overflow(ovf_m)
  );

  aud_recorder_mc #(.DATA_W(DW_S), .ADDR_W(AW_S), .N_CH(2), .MAX_LEN(8)) u_stereo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_data(i_data),
    .i_start(start_s), .i_pause(pause_s), .i_stop(stop_s),
    .o_address(addr_s), .o_data(data_s), .o_wr_valid(valid_s), .i_wr_ready(ready_s),
    .o_recd_len(len_s), .o_busy(busy_s), .o_full(full_s), .o_overflow(ovf_s)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Transfer monitors: sample mid-low-phase, after the bench has driven ready.
  always @(negedge i_clk) begin
    #2;
    if (valid_m) begin
      m_addr_q.push_back(addr_m);
      m_data_q.push_back(data_m);
    end
    if (valid_s && ready_s) begin
      s_addr_q.push_back(addr_s);
      s_data_q.push_back(data_s);
      s_busy_q.push_back(busy_s);
    end
    if (valid_s && !s_valid_q && !s_rise_seen) begin
      s_rise_seen  = 1'b1;
      s_rise_delta = cyc - lrc_rise_cyc;
    end
    s_valid_q = valid_s;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One I2S frame: LRC high half is channel 0, data lags LRC by one BCLK.
  task automatic send_frame(input logic [31:0] left, input logic [31:0] right, input int n_cyc,
                            input int rdy_lo_from, input int rdy_lo_to, input int pause_at);
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge i_clk);
      i_lrc = (i < 32);
      if (i >= 1 && i <= 32) i_data = left[32-i];
      else if (i >= 33)      i_data = right[64-i];
      else                   i_data = 1'b0;
      ready_s = !(i >= rdy_lo_from && i < rdy_lo_to);
      pause_s = (i == pause_at);
      if (i == 0) lrc_rise_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_lrc   = 1'b0;
      i_data  = 1'b0;
      ready_s = 1'b1;
    end
  endtask

  task automatic ctl_m(input logic st, input logic pa, input logic sp);
    @(negedge i_clk);
    start_m = st; pause_m = pa; stop_m = sp;
    @(negedge i_clk);
    start_m = 1'b0; pause_m = 1'b0; stop_m = 1'b0;
  endtask

  task automatic ctl_s(input logic st, input logic pa, input logic sp);
    @(negedge i_clk);
    start_s = st; pause_s = pa; stop_s = sp;
    @(negedge i_clk);
    start_s = 1'b0; pause_s = 1'b0; stop_s = 1'b0;
  endtask

  task automatic clear_s_queues();
    s_addr_q.delete();
    s_data_q.delete();
    s_busy_q.delete();
  endtask

  // Compare the stereo transfer log against an expected address/data list.
  task automatic check_s_log(input string tag, input int n, input int exp_addr [8], input logic [23:0] exp_data [8]);
    check({tag, "_count"}, 64'(s_addr_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < s_addr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(s_addr_q[i]), 64'(exp_addr[i]));
        check($sformatf("%s_data%0d", tag, i), 64'(s_data_q[i]), 64'(exp_data[i]));
      end
    end
  endtask

  logic [15:0] m_vals [4] = '{16'hA5C3, 16'h1234, 16'h8001, 16'hFFFF};
  int          exp_a  [8];
  logic [23:0] exp_d  [8];

  initial begin
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Reset state of the stereo instance.
    check("rst_addr",  64'(addr_s),  64'd0);
    check("rst_data",  64'(data_s),  64'd0);
    check("rst_valid", 64'(valid_s), 64'd0);
    check("rst_len",   64'(len_s),   64'd0);
    check("rst_busy",  64'(busy_s),  64'd0);
    check("rst_full",  64'(full_s),  64'd0);
    check("rst_ovf",   64'(ovf_s),   64'd0);

    // Mono, 16-bit, ready tied high: four frames, addresses 0..3.
    ctl_m(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_frame({m_vals[k], 16'h5A5A}, 32'h0F0F_F0F0, 64, -1, -1, -1);
    idle(4);
    check("mono_count", 64'(m_addr_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < m_addr_q.size()) begin
        check($sformatf("mono_addr%0d", k), 64'(m_addr_q[k]), 64'(k));
        check($sformatf("mono_data%0d", k), 64'(m_data_q[k]), 64'(m_vals[k]));
      end
    end
    check("mono_len",  64'(len_m),  64'd4);
    check("mono_busy", 64'(busy_m), 64'd1);
    check("mono_ovf",  64'(ovf_m),  64'd0);
    ctl_m(1'b0, 1'b0, 1'b1);

    // Stereo, 24-bit: three frames interleaved L/R, first valid 25 edges after detection.
    clear_s_queues();
    s_rise_seen = 1'b0;
    ctl_s(1'b1, 1'b0, 1'b0);
    repeat (3) send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, -1);
    idle(4);
    check("st_first_valid_lat", 64'(s_rise_delta), 64'd25);
    for (int i = 0; i < 6; i++) begin
      exp_a[i] = i;
      exp_d[i] = (i % 2 == 0) ? SL : SR;
    end
    check_s_log("st", 6, exp_a, exp_d);
    check("st_len", 64'(len_s), 64'd6);
    ctl_s(1'b0, 1'b0, 1'b1);
    idle(2);
    check("st_stop_busy", 64'(busy_s), 64'd0);

    // Backpressure: ready low for 40 BCLK across frame-2 completions drops the R word.
    clear_s_queues();
    ctl_s(1'b1, 1'b0, 1'b0);
    send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, -1);
    check("bp_ovf_before", 64'(ovf_s), 64'd0);
    send_frame(SL_SLOT, SR_SLOT, 64, 21, 61, -1);
    check("bp_ovf", 64'(ovf_s), 64'd1);
    check("bp_len_mid", 64'(len_s), 64'd3);
    send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, -1);
    idle(4);
    exp_a[0] = 0; exp_d[0] = SL;
    exp_a[1] = 1; exp_d[1] = SR;
    exp_a[2] = 2; exp_d[2] = SL;
    exp_a[3] = 4; exp_d[3] = SL;
    exp_a[4] = 5; exp_d[4] = SR;
    check_s_log("bp", 5, exp_a, exp_d);
    check("bp_len_end", 64'(len_s), 64'd6);
    ctl_s(1'b0, 1'b0, 1'b1);

    // Pause mid channel 0, resume, then run into the 8-word limit.
    clear_s_queues();
    ctl_s(1'b1, 1'b0, 1'b0);
    send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, 10);
    send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, -1);
    check("pause_words", 64'(s_addr_q.size()), 64'd2);
    check("pause_busy",  64'(busy_s), 64'd1);
    ctl_s(1'b1, 1'b0, 1'b0);
    repeat (3) send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, -1);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = i;
      exp_d[i] = (i % 2 == 0) ? SL : SR;
    end
    check_s_log("lim", 8, exp_a, exp_d);
    if (s_busy_q.size() == 8) check("lim_last_accept_busy", 64'(s_busy_q[7]), 64'd0);
    check("lim_full",  64'(full_s),  64'd1);
    check("lim_busy",  64'(busy_s),  64'd0);
    check("lim_valid", 64'(valid_s), 64'd0);
    check("lim_len",   64'(len_s),   64'd8);

    // Restart clears the limit; hold a word pending, then reset mid-frame.
    ctl_s(1'b1, 1'b0, 1'b0);
    check("restart_full", 64'(full_s), 64'd0);
    check("restart_len",  64'(len_s),  64'd0);
    send_frame(SL_SLOT, SR_SLOT, 40, 20, 64, -1);
    check("pend_valid", 64'(valid_s), 64'd1);
    check("pend_addr",  64'(addr_s),  64'd0);
    check("pend_data",  64'(data_s),  64'(SL));
    #1 i_rst_n = 1'b0;
    #1;
    check("arst_addr",  64'(addr_s),  64'd0);
    check("arst_data",  64'(data_s),  64'd0);
    check("arst_valid", 64'(valid_s), 64'd0);
    check("arst_len",   64'(len_s),   64'd0);
    check("arst_busy",  64'(busy_s),  64'd0);
    check("arst_full",  64'(full_s),  64'd0);
    check("arst_ovf",   64'(ovf_s),   64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_s_queues();
    repeat (2) send_frame(SL_SLOT, SR_SLOT, 64, -1, -1, -1);
    idle(4);
    check("post_rst_words", 64'(s_addr_q.size()), 64'd0);
    check("post_rst_busy",  64'(busy_s),  64'd0);
    check("post_rst_valid", 64'(valid_s), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
